// File: rtl/vga_debug_scanner.sv
// -----------------------------------------------------------------------------
// vga_debug_scanner
//
// Sweeps NUM_CH debug channels of DATA_W bits and renders each as upper-case
// hex text into the VGA text buffer, one character per clock. Each channel
// occupies NIB = DATA_W/4 digits followed by one space. Channels are laid out
// CH_PER_ROW per text row with a column pitch of FIELD_W characters.
//
// A sweep takes a coherent snapshot of all channels (and their valid bits) as
// it leaves SNAP, so input changes during the write phase never tear a frame.
// With freeze held, the previous snapshot is reused. Invalid channels render
// as dashes. CONTINUOUS=1 re-runs sweeps back to back; CONTINUOUS=0 runs one
// sweep per start pulse (pulses while busy are dropped).
//
// Ports
//   clk        : system clock (display write-port domain)
//   rst        : asynchronous reset, active low
//   ch_data    : flattened channel values, channel i at [i*DATA_W +: DATA_W]
//   ch_valid   : per-channel valid, 0 renders the channel as dashes
//   start      : one-shot sweep request (CONTINUOUS=0 only)
//   freeze     : 1 = reuse the previous snapshot at the next SNAP
//   wen        : text-buffer write enable
//   w_addr     : text-buffer address
//   w_data     : ASCII character
//   busy       : high from SNAP through the last write of a sweep
//   frame_done : one-cycle pulse once a sweep has completed
// -----------------------------------------------------------------------------
module vga_debug_scanner #(
   parameter int NUM_CH     = 16,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 12,
   parameter int COLS       = 80,
   parameter int CH_PER_ROW = 4,
   parameter int FIELD_W    = 10,
   parameter int BASE_ADDR  = 0,
   parameter int CONTINUOUS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic                     start,
   input  logic                     freeze,
   output logic                     wen,
   output logic [ADDR_W-1:0]        w_addr,
   output logic [7:0]               w_data,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int NIB   = DATA_W / 4;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NIB_W = $clog2(NIB + 1);

   if (DATA_W % 4 != 0) begin : g_bad_data_w
      $error("vga_debug_scanner: DATA_W must be a multiple of 4");
   end
   if (FIELD_W < NIB + 1) begin : g_bad_field_w
      $error("vga_debug_scanner: FIELD_W must be at least DATA_W/4 + 1");
   end
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("vga_debug_scanner: NUM_CH must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SNAP  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // ASCII for one hex digit: '0'..'9' then 'A'..'F'
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   // Text-buffer address of a channel/digit; wraps silently at ADDR_W bits
   function automatic logic [ADDR_W-1:0] char_addr(input logic [CH_W-1:0]  ch,
                                                   input logic [NIB_W-1:0] nib);
      return ADDR_W'(32'(BASE_ADDR)
                     + (32'(ch) / 32'(CH_PER_ROW)) * 32'(COLS)
                     + (32'(ch) % 32'(CH_PER_ROW)) * 32'(FIELD_W)
                     + 32'(nib));
   endfunction

   state_t                    state_q;
   logic                      start_q;
   logic [CH_W-1:0]           ch_idx_q;
   logic [CH_W-1:0]           ch_idx_d;
   logic [NIB_W-1:0]          nib_idx_q;
   logic [NIB_W-1:0]          nib_idx_d;
   logic [NUM_CH*DATA_W-1:0]  snap_q;
   logic [NUM_CH-1:0]         snap_vld_q;
   logic                      wen_q;
   logic [ADDR_W-1:0]         w_addr_q;
   logic [7:0]                w_data_q;
   logic                      busy_q;
   logic                      frame_done_q;

   logic                      last_char;
   logic                      use_live;
   logic [NUM_CH*DATA_W-1:0]  src_data;
   logic [NUM_CH-1:0]         src_valid;
   logic [DATA_W-1:0]         src_word;
   logic [3:0]                src_nib;
   logic [ADDR_W-1:0]         w_addr_d;
   logic [7:0]                w_data_d;

   // The separator of the final channel is the last character of a sweep
   assign last_char = (ch_idx_q == CH_W'(NUM_CH - 1)) && (nib_idx_q == NIB_W'(NIB));

   // Index of the character to be presented after the coming edge.
   // Digit NIB of each channel is the separator slot.
   always_comb begin
      ch_idx_d  = ch_idx_q;
      nib_idx_d = nib_idx_q;
      if ((state_q != S_WRITE) || last_char) begin
         ch_idx_d  = '0;
         nib_idx_d = '0;
      end else if (nib_idx_q == NIB_W'(NIB)) begin
         ch_idx_d  = ch_idx_q + CH_W'(1);
         nib_idx_d = '0;
      end else begin
         nib_idx_d = nib_idx_q + NIB_W'(1);
      end
   end

   // The first character leaves SNAP on the same edge that loads the snapshot,
   // so it is rendered straight from the live inputs unless frozen.
   assign use_live  = (state_q == S_SNAP) && !freeze;
   assign src_data  = use_live ? ch_data  : snap_q;
   assign src_valid = use_live ? ch_valid : snap_vld_q;
   assign src_word  = src_data[32'(ch_idx_d) * DATA_W +: DATA_W];

   // MSB nibble first; the shift overflows to zero on the separator slot,
   // whose value is not used.
   assign src_nib = 4'(src_word >> ((32'(NIB - 1) - 32'(nib_idx_d)) * 32'd4));

   assign w_data_d = (nib_idx_d == NIB_W'(NIB)) ? 8'h20 :
                     (src_valid[ch_idx_d] ? hex_char(src_nib) : 8'h2D);
   assign w_addr_d = char_addr(ch_idx_d, nib_idx_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         ch_idx_q     <= '0;
         nib_idx_q    <= '0;
         snap_q       <= '0;
         snap_vld_q   <= '0;
         wen_q        <= 1'b0;
         w_addr_q     <= '0;
         w_data_q     <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         // Requests are only latched while idle, so pulses during a sweep are lost
         start_q      <= start && (state_q == S_IDLE) && (CONTINUOUS == 0);

         case (state_q)
            S_IDLE: begin
               if ((CONTINUOUS != 0) || start_q) begin
                  state_q <= S_SNAP;
                  busy_q  <= 1'b1;
               end
            end

            S_SNAP: begin
               if (!freeze) begin
                  snap_q     <= ch_data;
                  snap_vld_q <= ch_valid;
               end
               ch_idx_q  <= ch_idx_d;
               nib_idx_q <= nib_idx_d;
               wen_q     <= 1'b1;
               w_addr_q  <= w_addr_d;
               w_data_q  <= w_data_d;
               state_q   <= S_WRITE;
            end

            S_WRITE: begin
               if (last_char) begin
                  wen_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  ch_idx_q  <= ch_idx_d;
                  nib_idx_q <= nib_idx_d;
                  w_addr_q  <= w_addr_d;
                  w_data_q  <= w_data_d;
               end
            end

            S_DONE: begin
               ch_idx_q     <= '0;
               nib_idx_q    <= '0;
               frame_done_q <= 1'b1;
               state_q      <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign wen        = wen_q;
   assign w_addr     = w_addr_q;
   assign w_data     = w_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_debug_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_debug_scanner
//
// Two scanner instances share one clock:
//   u_dut0 : NUM_CH=2, one-shot sweeps on start
//   u_dut1 : NUM_CH=5, continuous sweeps
// Written characters are collected on the falling edge and compared with
// hand-written text strings and addresses.
// -----------------------------------------------------------------------------
module tb_vga_debug_scanner;

   logic         clk;
   logic         rst0;
   logic         rst1;

   logic [63:0]  ch_data0;
   logic [1:0]   ch_valid0;
   logic         start0;
   logic         freeze0;
   logic         wen0;
   logic [11:0]  w_addr0;
   logic [7:0]   w_data0;
   logic         busy0;
   logic         frame_done0;

   logic [159:0] ch_data1;
   logic [4:0]   ch_valid1;
   logic         start1;
   logic         freeze1;
   logic         wen1;
   logic [11:0]  w_addr1;
   logic [7:0]   w_data1;
   logic         busy1;
   logic         frame_done1;

   int           cyc     = 0;
   int           n_chk   = 0;
   int           n_pass  = 0;
   int           fd_cnt0 = 0;
   int           fd_cyc0 = 0;
   int           t_start = 0;
   logic [19:0]  q0[$];
   logic [19:0]  q1[$];
   int           fdq1[$];

   vga_debug_scanner #(.NUM_CH(2), .CONTINUOUS(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst0),
      .ch_data    (ch_data0),
      .ch_valid   (ch_valid0),
      .start      (start0),
      .freeze     (freeze0),
      .wen        (wen0),
      .w_addr     (w_addr0),
      .w_data     (w_data0),
      .busy       (busy0),
      .frame_done (frame_done0)
   );

   vga_debug_scanner #(.NUM_CH(5), .CONTINUOUS(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst1),
      .ch_data    (ch_data1),
      .ch_valid   (ch_valid1),
      .start      (start1),
      .freeze     (freeze1),
      .wen        (wen1),
      .w_addr     (w_addr1),
      .w_data     (w_data1),
      .busy       (busy1),
      .frame_done (frame_done1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wen0) q0.push_back({w_addr0, w_data0});
      if (frame_done0) begin
         fd_cnt0++;
         fd_cyc0 = cyc;
      end
      if (wen1) q1.push_back({w_addr1, w_data1});
      if (frame_done1) fdq1.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
   endtask

   task automatic do_start();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 t_start = cyc;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_fd0(input string tag, input int c0, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (fd_cnt0 != c0) break;
         @(negedge clk);
         #1;
      end
      check({tag, "_fd_seen"}, 32'(fd_cnt0 - c0), 32'd1);
   endtask

   // Compare the 18 collected writes with channel 0 text s0 and channel 1 text s1
   task automatic check_sweep(input string tag, input string s0, input string s1);
      logic [19:0] got;
      logic [19:0] exp;
      logic [7:0]  c;
      int          ch;
      int          n;
      check({tag, "_nwr"}, 32'(q0.size()), 32'd18);
      for (int i = 0; i < 18; i++) begin
         ch  = i / 9;
         n   = i % 9;
         c   = (ch == 0) ? 8'(s0[n]) : 8'(s1[n]);
         exp = {12'(ch * 10 + n), c};
         got = (i < q0.size()) ? q0[i] : 20'hFFFFF;
         check($sformatf("%s_wr%0d", tag, i), 32'(got), 32'(exp));
      end
   endtask

   task automatic sweep0(input string tag, input string s0, input string s1);
      int c0;
      q0.delete();
      c0 = fd_cnt0;
      do_start();
      wait_fd0(tag, c0, 60);
      check({tag, "_latency"}, 32'(fd_cyc0 - t_start), 32'd21);
      repeat (3) @(negedge clk);
      check_sweep(tag, s0, s1);
   endtask

   initial begin
      int          c0;
      string       s4;
      logic [19:0] got;
      logic [7:0]  c;

      rst0      = 1'b1;
      rst1      = 1'b1;
      ch_data0  = '0;
      ch_valid0 = '0;
      start0    = 1'b0;
      freeze0   = 1'b0;
      ch_data1  = {32'hC0FF_EE99, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
      ch_valid1 = 5'h1F;
      start1    = 1'b0;
      freeze1   = 1'b0;

      // Reset values of both instances
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      #2;
      check("rst0_wen",  32'(wen0),        32'd0);
      check("rst0_busy", 32'(busy0),       32'd0);
      check("rst0_fd",   32'(frame_done0), 32'd0);
      check("rst0_addr", 32'(w_addr0),     32'd0);
      check("rst0_data", 32'(w_data0),     32'd0);
      check("rst1_wen",  32'(wen1),        32'd0);
      check("rst1_busy", 32'(busy1),       32'd0);
      check("rst1_fd",   32'(frame_done1), 32'd0);
      check("rst1_addr", 32'(w_addr1),     32'd0);
      check("rst1_data", 32'(w_data1),     32'd0);

      @(negedge clk);
      rst0 = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_no_auto_wr", 32'(q0.size()), 32'd0);
      check("idle_busy",       32'(busy0),     32'd0);

      // A: basic sweep, both channels valid
      ch_data0  = {32'h0000_00FF, 32'hDEAD_BEEF};
      ch_valid0 = 2'b11;
      sweep0("A", "DEADBEEF ", "000000FF ");
      c0 = fd_cnt0;
      repeat (10) @(negedge clk);
      check("A_no_extra_wr", 32'(q0.size()),   32'd18);
      check("A_no_extra_fd", 32'(fd_cnt0 - c0), 32'd0);
      check("A_busy_after",  32'(busy0),       32'd0);

      // B: channel 0 invalid renders as dashes
      ch_data0  = {32'hDEAD_BEEF, 32'h0000_00FF};
      ch_valid0 = 2'b10;
      sweep0("B", "-------- ", "DEADBEEF ");

      // C: freeze keeps the old snapshot for one sweep
      ch_data0  = {32'h0000_0000, 32'h1234_5678};
      ch_valid0 = 2'b11;
      sweep0("C1", "12345678 ", "00000000 ");
      freeze0  = 1'b1;
      ch_data0 = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      sweep0("C2", "12345678 ", "00000000 ");
      freeze0  = 1'b0;
      sweep0("C3", "FFFFFFFF ", "FFFFFFFF ");

      // D: inputs change during the first write cycle
      ch_data0  = {32'h0123_4567, 32'hAAAA_5555};
      ch_valid0 = 2'b11;
      q0.delete();
      c0 = fd_cnt0;
      do_start();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("D_busy_write", 32'(busy0), 32'd1);
      check("D_wen_write",  32'(wen0),  32'd1);
      ch_data0  = {32'h0F0F_0F0F, 32'h0F0F_0F0F};
      ch_valid0 = 2'b01;
      wait_fd0("D1", c0, 60);
      check("D1_latency", 32'(fd_cyc0 - t_start), 32'd21);
      repeat (3) @(negedge clk);
      check_sweep("D1", "AAAA5555 ", "01234567 ");
      sweep0("D2", "0F0F0F0F ", "-------- ");

      // E: reset during channel 0 digit 3
      ch_data0  = {32'h7654_3210, 32'h89AB_CDEF};
      ch_valid0 = 2'b11;
      q0.delete();
      c0 = fd_cnt0;
      do_start();
      repeat (5) @(posedge clk);
      #2;
      check("E_pre_addr", 32'(w_addr0), 32'd3);
      check("E_pre_wen",  32'(wen0),    32'd1);
      check("E_pre_data", 32'(w_data0), 32'h42);
      rst0 = 1'b0;
      #1;
      check("E_rst_wen",  32'(wen0),        32'd0);
      check("E_rst_busy", 32'(busy0),       32'd0);
      check("E_rst_fd",   32'(frame_done0), 32'd0);
      check("E_rst_addr", 32'(w_addr0),     32'd0);
      check("E_rst_data", 32'(w_data0),     32'd0);
      @(negedge clk);
      @(negedge clk);
      rst0 = 1'b1;
      repeat (40) @(negedge clk);
      check("E_no_fd",   32'(fd_cnt0 - c0), 32'd0);
      check("E_idle",    32'(busy0),       32'd0);
      sweep0("E", "89ABCDEF ", "76543210 ");

      // F: start while busy is dropped
      ch_data0  = {32'h0000_0000, 32'h1234_5678};
      ch_valid0 = 2'b11;
      q0.delete();
      c0 = fd_cnt0;
      do_start();
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_fd0("F", c0, 60);
      repeat (40) @(negedge clk);
      check("F_one_fd",  32'(fd_cnt0 - c0), 32'd1);
      check("F_one_swp", 32'(q0.size()),   32'd18);

      // G: continuous instance, channel 4 wraps to row 1
      @(negedge clk);
      rst1 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (fdq1.size() >= 3) break;
         @(negedge clk);
         #1;
      end
      check("G_three_fd", 32'(fdq1.size() >= 3), 32'd1);
      check("G_period01", (fdq1.size() >= 3) ? 32'(fdq1[1] - fdq1[0]) : 32'hFFFF_FFFF, 32'd48);
      check("G_period12", (fdq1.size() >= 3) ? 32'(fdq1[2] - fdq1[1]) : 32'hFFFF_FFFF, 32'd48);
      got = (q1.size() > 35) ? q1[35] : 20'hFFFFF;
      check("G_ch3_sep", 32'(got), 32'({12'd38, 8'h20}));
      s4 = "C0FFEE99 ";
      for (int n = 0; n < 9; n++) begin
         c   = 8'(s4[n]);
         got = (q1.size() > 36 + n) ? q1[36 + n] : 20'hFFFFF;
         check($sformatf("G_ch4_wr%0d", n), 32'(got), 32'({12'(80 + n), c}));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
